// File: rtl/video_source_switch.sv
// video_source_switch: frame-synchronous RGB source selector with optional fade-to-black transitions.
// Ports: clk (system clock), rst_b (async active-low reset), sel (async channel request),
//   pix_in (NCH packed {R,G,B} words, channel k at bits [(k+1)*3*CW-1 : k*3*CW]),
//   col/row (VGA raster position), pix_out (selected, scaled {R,G,B}; 2-clk latency),
//   active_sel (channel currently shown), busy (switch pending or fade in progress).
// Build option: define VIDEO_SOURCE_SWITCH_FADE_EN to fade out/in across a switch;
//   otherwise the switch is an immediate cut at the next frame start.
module video_source_switch #(
  parameter int NCH = 8,
  parameter int CW = 8,
  parameter int FADE_STEPS = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [SELW-1:0]       sel,
  input  logic [NCH*3*CW-1:0]   pix_in,
  input  logic [10:0]           col,
  input  logic [10:0]           row,
  output logic [3*CW-1:0]       pix_out,
  output logic [SELW-1:0]       active_sel,
  output logic                  busy
);
  localparam int FSB = $clog2(FADE_STEPS);
  localparam int LW = FSB + 1;
  localparam logic [LW-1:0] FULL = LW'(FADE_STEPS);
  localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

  logic [SELW-1:0] sync_a, sync_b, last_valid, pending, act_nx;
  logic            zero_q, at_zero, frame_start;
  logic [LW-1:0]   level, lvl_q;
  logic [3*CW-1:0] pix_q, scaled;

  // Out-of-range requests fall back to the last valid one.
  assign pending = ({1'b0, sync_b} < NCH_W) ? sync_b : last_valid;
  assign at_zero = (row == '0) && (col == '0);
  // zero_q resets high so no frame start is seen until (0,0) is actually entered.
  assign frame_start = at_zero && !zero_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_a     <= '0;
      sync_b     <= '0;
      last_valid <= '0;
      zero_q     <= 1'b1;
      active_sel <= '0;
      pix_q      <= '0;
      lvl_q      <= FULL;
      pix_out    <= '0;
    end else begin
      sync_a     <= sel;
      sync_b     <= sync_a;
      last_valid <= pending;
      zero_q     <= at_zero;
      active_sel <= act_nx;
      pix_q      <= pix_in[32'(active_sel) * 3 * CW +: 3 * CW];
      lvl_q      <= level;
      pix_out    <= scaled;
    end
  end

  // Per-component (pix * level) / FADE_STEPS, truncating.
  for (genvar i = 0; i < 3; i++) begin : g_scale
    logic [CW+LW-1:0] p;
    assign p = {{LW{1'b0}}, pix_q[i*CW +: CW]} * {{CW{1'b0}}, lvl_q};
    assign scaled[i*CW +: CW] = CW'(p >> FSB);
  end

`ifdef VIDEO_SOURCE_SWITCH_FADE_EN
  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
  state_t        state, state_nx;
  logic [LW-1:0] level_nx;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      level <= FULL;
    end else begin
      state <= state_nx;
      level <= level_nx;
    end
  end

  // The entering frame start already takes the first step down, and the
  // switching frame start (level 0) already takes the first step up, so a
  // full transition spans 2*FADE_STEPS frames.
  always_comb begin
    state_nx = state;
    level_nx = level;
    act_nx   = active_sel;
    if (frame_start) begin
      if (state == IDLE && pending != active_sel) begin
        state_nx = FADE_OUT;
        level_nx = level - 1'b1;
      end else if (state == FADE_OUT && level != '0) begin
        level_nx = level - 1'b1;
      end else if (state == FADE_OUT) begin
        state_nx = FADE_IN;
        level_nx = LW'(1);
        act_nx   = pending;
      end else if (state == FADE_IN) begin
        level_nx = level + 1'b1;
        state_nx = (level == FULL - 1'b1) ? IDLE : FADE_IN;
      end
    end
  end

  assign busy = (pending != active_sel) || (state != IDLE);
`else
  assign level  = FULL;
  assign act_nx = frame_start ? pending : active_sel;
  assign busy   = pending != active_sel;
`endif
endmodule

// File: tb/tb_video_source_switch.sv
// tb_video_source_switch: directed, table-driven check of video_source_switch (default and NCH=6 instances).
module tb_video_source_switch;
  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic [2:0]    sel = '0, sel6 = '0;
  logic [10:0]   row = 11'd5, col = 11'd5;
  logic [191:0]  pix;
  logic [143:0]  pix6;
  logic [23:0]   pout, pout6;
  logic [2:0]    act, act6;
  logic          busy, busy6;
  int            total = 0, bad = 0;

  always #10 clk = ~clk;

  video_source_switch dut (
    .clk(clk), .rst_b(rst_b), .sel(sel), .pix_in(pix), .col(col), .row(row),
    .pix_out(pout), .active_sel(act), .busy(busy)
  );

  video_source_switch #(.NCH(6)) dut6 (
    .clk(clk), .rst_b(rst_b), .sel(sel6), .pix_in(pix6), .col(col), .row(row),
    .pix_out(pout6), .active_sel(act6), .busy(busy6)
  );

  typedef struct {
    logic [2:0]  s, s6, ea, ea6;
    logic [23:0] eo, eo6;
  } rec_t;

  rec_t       tab [6];
  logic [7:0] lv [9];
  logic [2:0] prev_a, prev_a6;

  function automatic logic [23:0] chv(input int k);
    return 24'h102030 + 24'(k) * 24'h010101;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int n);
    row = '0;
    col = '0;
    tick;
    row = 11'd1;
    col = '0;
    repeat (n) tick;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) pix[k*24 +: 24] = chv(k);
    for (int k = 0; k < 6; k++) pix6[k*24 +: 24] = chv(k);
    lv = '{8'h00, 8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F, 8'hBF, 8'hDF, 8'hFF};
    tab[0] = '{3'd5, 3'd7, 3'd5, 3'd0, 24'h152535, 24'h102030};
    tab[1] = '{3'd7, 3'd5, 3'd7, 3'd5, 24'h172737, 24'h152535};
    tab[2] = '{3'd0, 3'd6, 3'd0, 3'd5, 24'h102030, 24'h152535};
    tab[3] = '{3'd2, 3'd2, 3'd2, 3'd2, 24'h122232, 24'h122232};
    tab[4] = '{3'd2, 3'd7, 3'd2, 3'd2, 24'h122232, 24'h122232};
    tab[5] = '{3'd1, 3'd0, 3'd1, 3'd0, 24'h112131, 24'h102030};

    #25;
    chk("rst_pix", 32'(pout), 32'h0);
    chk("rst_act", 32'(act), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pix6", 32'(pout6), 32'h0);
    tick;
    rst_b = 1'b1;
    tick;
    chk("post_rst_1", 32'(pout), 32'h0);
    tick;
    chk("post_rst_2", 32'(pout), 32'h102030);
    frame(2);
    chk("first_frame_pix", 32'(pout), 32'h102030);
    chk("first_frame_act", 32'(act), 32'h0);
    chk("first_frame_busy", 32'(busy), 32'h0);

`ifndef VIDEO_SOURCE_SWITCH_FADE_EN
    sel = 3'd3;
    tick;
    chk("busy_sync1", 32'(busy), 32'h0);
    tick;
    chk("busy_sync2", 32'(busy), 32'h1);
    chk("act_hold_sync", 32'(act), 32'h0);
    repeat (3) tick;
    chk("busy_midframe", 32'(busy), 32'h1);
    chk("act_midframe", 32'(act), 32'h0);
    row = '0;
    col = '0;
    tick;
    chk("act_at_fs", 32'(act), 32'h3);
    chk("busy_at_fs", 32'(busy), 32'h0);
    chk("lat0", 32'(pout), 32'h102030);
    row = 11'd1;
    tick;
    chk("lat1", 32'(pout), 32'h102030);
    tick;
    chk("lat2", 32'(pout), 32'h132333);

    row = '0;
    col = '0;
    tick;
    sel = 3'd5;
    repeat (4) tick;
    chk("hold_no_fs_act", 32'(act), 32'h3);
    chk("hold_no_fs_busy", 32'(busy), 32'h1);
    row = 11'd1;
    tick;
    row = '0;
    tick;
    chk("next_fs_act", 32'(act), 32'h5);
    chk("next_fs_busy", 32'(busy), 32'h0);

    prev_a = 3'd5;
    prev_a6 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      sel = tab[i].s;
      sel6 = tab[i].s6;
      repeat (3) tick;
      chk($sformatf("tab%0d_busy", i), 32'(busy), 32'(tab[i].ea != prev_a));
      chk($sformatf("tab%0d_busy6", i), 32'(busy6), 32'(tab[i].ea6 != prev_a6));
      frame(3);
      chk($sformatf("tab%0d_act", i), 32'(act), 32'(tab[i].ea));
      chk($sformatf("tab%0d_act6", i), 32'(act6), 32'(tab[i].ea6));
      chk($sformatf("tab%0d_pix", i), 32'(pout), 32'(tab[i].eo));
      chk($sformatf("tab%0d_pix6", i), 32'(pout6), 32'(tab[i].eo6));
      chk($sformatf("tab%0d_idle", i), 32'({busy, busy6}), 32'h0);
      prev_a = tab[i].ea;
      prev_a6 = tab[i].ea6;
    end

    pix[24 +: 24] = 24'hABCDEF;
    tick;
    chk("pix_lat1", 32'(pout), 32'h112131);
    tick;
    chk("pix_lat2", 32'(pout), 32'hABCDEF);

    rst_b = 1'b0;
    #2;
    chk("midrst_pix", 32'(pout), 32'h0);
    chk("midrst_act", 32'(act), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    sel = 3'd0;
    tick;
    rst_b = 1'b1;
    repeat (2) tick;
    chk("after_rst_pix", 32'(pout), 32'h102030);
    chk("after_rst_busy", 32'(busy), 32'h0);
`else
    pix[0 +: 24]  = 24'hFF0000;
    pix[24 +: 24] = 24'h0000FF;
    pix[48 +: 24] = 24'h00FF00;
    sel = 3'd1;
    repeat (3) tick;
    chk("fade_req_busy", 32'(busy), 32'h1);
    chk("fade_req_act", 32'(act), 32'h0);
    for (int f = 1; f <= 16; f++) begin
      frame(3);
      chk($sformatf("fade_f%0d_pix", f), 32'(pout),
          f <= 8 ? 32'({lv[8-f], 16'h0}) : 32'({16'h0, lv[f-8]}));
      chk($sformatf("fade_f%0d_act", f), 32'(act), f <= 8 ? 32'h0 : 32'h1);
      chk($sformatf("fade_f%0d_busy", f), 32'(busy), f < 16 ? 32'h1 : 32'h0);
    end

    sel = 3'd0;
    repeat (3) tick;
    repeat (4) frame(3);
    chk("lvl4_pix", 32'(pout), 32'h00007F);
    rst_b = 1'b0;
    #2;
    chk("fade_rst_pix", 32'(pout), 32'h0);
    chk("fade_rst_act", 32'(act), 32'h0);
    chk("fade_rst_busy", 32'(busy), 32'h0);
    tick;
    rst_b = 1'b1;
    repeat (2) tick;
    chk("fade_after_rst_pix", 32'(pout), 32'hFF0000);
    chk("fade_after_rst_busy", 32'(busy), 32'h0);

    sel = 3'd1;
    repeat (3) tick;
    for (int f = 1; f <= 16; f++) begin
      frame(3);
      chk($sformatf("retgt_f%0d_pix", f), 32'(pout),
          f <= 8 ? 32'({lv[8-f], 16'h0}) : 32'({8'h0, lv[f-8], 8'h0}));
      chk($sformatf("retgt_f%0d_act", f), 32'(act), f <= 8 ? 32'h0 : 32'h2);
      chk($sformatf("retgt_f%0d_busy", f), 32'(busy), f < 16 ? 32'h1 : 32'h0);
      if (f == 5) sel = 3'd2;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
